// File: rtl/mmpu_op_sequencer.sv
// Sequences one mMPU crossbar operation at a time: destination init (NOT/NOR), evaluation,
// and drive_en gating so every pulse starts only after its decoder fields have settled.
module mmpu_op_sequencer #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned EVAL_CYCLES = 8,
    parameter int unsigned RW_CYCLES   = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              cmd_col,
    input  logic [ADDR_W-1:0] cmd_dest,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [ADDR_W-1:0] cmd_start,
    input  logic [ADDR_W-1:0] cmd_endx,
    output logic [1:0]        mem_op,
    output logic              col_flag,
    output logic [ADDR_W-1:0] dest_addr,
    output logic [ADDR_W-1:0] src1_addr,
    output logic [ADDR_W-1:0] src2_addr,
    output logic [ADDR_W-1:0] start,
    output logic [ADDR_W-1:0] endx,
    output logic              drive_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_INIT_SETUP = 3'd1;
    localparam logic [2:0] S_INIT_PULSE = 3'd2;
    localparam logic [2:0] S_EVAL_SETUP = 3'd3;
    localparam logic [2:0] S_EVAL_PULSE = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    localparam logic [CNT_W-1:0]  INIT_LOAD = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  EVAL_LOAD = CNT_W'(EVAL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RW_LOAD   = CNT_W'(RW_CYCLES - 1);
    localparam logic [ADDR_W-1:0] EMPTY_LO  = {ADDR_W{1'b1}};

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Captured command
    logic [1:0]        op_q, op_d;
    logic              col_q, col_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [ADDR_W-1:0] src1_q, src1_d;
    logic [ADDR_W-1:0] src2_q, src2_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] endx_q, endx_d;
    logic              rej_q, rej_d;

    // Registered outputs
    logic              cmd_ready_q, cmd_ready_d;
    logic [1:0]        mem_op_q, mem_op_d;
    logic              col_flag_q, col_flag_d;
    logic [ADDR_W-1:0] dest_addr_q, dest_addr_d;
    logic [ADDR_W-1:0] src1_addr_q, src1_addr_d;
    logic [ADDR_W-1:0] src2_addr_q, src2_addr_d;
    logic [ADDR_W-1:0] start_o_q, start_o_d;
    logic [ADDR_W-1:0] endx_o_q, endx_o_d;
    logic              drive_en_q, drive_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept_c;
    logic              bad_c;

    assign accept_c = cmd_valid && cmd_ready_q;

    // Command legality, evaluated on the raw inputs at the accept edge
    always_comb begin
        bad_c = (cmd_start > cmd_endx);
        case (cmd_op)
            2'b00:   bad_c = bad_c || (cmd_dest == cmd_src1);
            2'b01:   bad_c = bad_c || (cmd_dest == cmd_src1) || (cmd_dest == cmd_src2);
            default: bad_c = bad_c || (cmd_src1 > cmd_src2);
        endcase
    end

    // Next state, counter and capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        col_d   = col_q;
        dest_d  = dest_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        start_d = start_q;
        endx_d  = endx_q;
        rej_d   = rej_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    op_d    = cmd_op;
                    col_d   = cmd_col;
                    dest_d  = cmd_dest;
                    src1_d  = cmd_src1;
                    src2_d  = cmd_src2;
                    start_d = cmd_start;
                    endx_d  = cmd_endx;
                    rej_d   = bad_c;
                    if (bad_c)          state_d = S_DONE;
                    else if (cmd_op[1]) state_d = S_EVAL_SETUP;
                    else                state_d = S_INIT_SETUP;
                end
            end
            S_INIT_SETUP: begin
                state_d = S_INIT_PULSE;
                cnt_d   = INIT_LOAD;
            end
            S_INIT_PULSE: begin
                if (cnt_q == '0) state_d = S_EVAL_SETUP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_EVAL_SETUP: begin
                state_d = S_EVAL_PULSE;
                cnt_d   = op_q[1] ? RW_LOAD : EVAL_LOAD;
            end
            S_EVAL_PULSE: begin
                if (cnt_q == '0) state_d = S_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values registered from the current phase; idle fields describe an empty range
    always_comb begin
        mem_op_d    = 2'b00;
        col_flag_d  = 1'b0;
        dest_addr_d = '0;
        src1_addr_d = '0;
        src2_addr_d = '0;
        start_o_d   = EMPTY_LO;
        endx_o_d    = '0;
        drive_en_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_INIT_SETUP, S_INIT_PULSE: begin
                mem_op_d    = 2'b10;
                col_flag_d  = col_q;
                dest_addr_d = dest_q;
                src1_addr_d = dest_q;
                src2_addr_d = dest_q;
                start_o_d   = start_q;
                endx_o_d    = endx_q;
                drive_en_d  = (state_q == S_INIT_PULSE);
            end
            S_EVAL_SETUP, S_EVAL_PULSE: begin
                mem_op_d    = op_q;
                col_flag_d  = col_q;
                dest_addr_d = dest_q;
                src1_addr_d = src1_q;
                src2_addr_d = src2_q;
                start_o_d   = start_q;
                endx_o_d    = endx_q;
                drive_en_d  = (state_q == S_EVAL_PULSE);
            end
            S_DONE: begin
                done_d = 1'b1;
                err_d  = rej_q;
            end
            default: ;
        endcase
        // Handshake flags react at the accept edge itself so no second command slips in
        cmd_ready_d = (state_q == S_IDLE) && !accept_c;
        busy_d      = (state_q != S_IDLE) || accept_c;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= 2'b00;
            col_q       <= 1'b0;
            dest_q      <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            start_q     <= '0;
            endx_q      <= '0;
            rej_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            mem_op_q    <= 2'b00;
            col_flag_q  <= 1'b0;
            dest_addr_q <= '0;
            src1_addr_q <= '0;
            src2_addr_q <= '0;
            start_o_q   <= EMPTY_LO;
            endx_o_q    <= '0;
            drive_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            col_q       <= col_d;
            dest_q      <= dest_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            start_q     <= start_d;
            endx_q      <= endx_d;
            rej_q       <= rej_d;
            cmd_ready_q <= cmd_ready_d;
            mem_op_q    <= mem_op_d;
            col_flag_q  <= col_flag_d;
            dest_addr_q <= dest_addr_d;
            src1_addr_q <= src1_addr_d;
            src2_addr_q <= src2_addr_d;
            start_o_q   <= start_o_d;
            endx_o_q    <= endx_o_d;
            drive_en_q  <= drive_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign mem_op    = mem_op_q;
    assign col_flag  = col_flag_q;
    assign dest_addr = dest_addr_q;
    assign src1_addr = src1_addr_q;
    assign src2_addr = src2_addr_q;
    assign start     = start_o_q;
    assign endx      = endx_o_q;
    assign drive_en  = drive_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mmpu_op_sequencer.sv
// Scoreboard bench for mmpu_op_sequencer: the driver predicts each command's phase timeline
// from its accept cycle; a monitor compares every cycle's outputs against the queue head.
module tb_mmpu_op_sequencer;

    localparam int unsigned AW = 10;
    localparam int NI = 4;
    localparam int NE = 8;
    localparam int NR = 2;

    logic          clock;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic          cmd_col;
    logic [AW-1:0] cmd_dest, cmd_src1, cmd_src2, cmd_start, cmd_endx;
    logic [1:0]    mem_op;
    logic          col_flag;
    logic [AW-1:0] dest_addr, src1_addr, src2_addr, start, endx;
    logic          drive_en, busy, done, err;

    mmpu_op_sequencer dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_col(cmd_col),
        .cmd_dest(cmd_dest), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
        .cmd_start(cmd_start), .cmd_endx(cmd_endx),
        .mem_op(mem_op), .col_flag(col_flag),
        .dest_addr(dest_addr), .src1_addr(src1_addr), .src2_addr(src2_addr),
        .start(start), .endx(endx),
        .drive_en(drive_en), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        int            i_lo, i_hi, e_lo, e_hi, done_c;
        logic          err;
        logic [1:0]    op;
        logic          col;
        logic [AW-1:0] dest, s1, s2, st, en;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic mon_en = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] idle_fields();
        logic [AW-1:0] ones;
        ones = '1;
        return 64'({2'b00, 1'b0, {AW{1'b0}}, {AW{1'b0}}, {AW{1'b0}}, ones, {AW{1'b0}}});
    endfunction

    // Reference model: phase windows derived from the command rules and cycle budgets
    function automatic exp_t predict(input int t, input logic [1:0] op, input logic col,
                                     input logic [AW-1:0] d, s1, s2, st, en);
        exp_t r;
        logic bad;
        bad = (st > en);
        if (op == 2'b00) bad = bad || (d == s1);
        if (op == 2'b01) bad = bad || (d == s1) || (d == s2);
        if (op >= 2'b10) bad = bad || (s1 > s2);
        r.op = op; r.col = col; r.dest = d; r.s1 = s1; r.s2 = s2; r.st = st; r.en = en;
        r.err = bad;
        r.i_lo = 1; r.i_hi = 0; r.e_lo = 1; r.e_hi = 0;
        if (bad) begin
            r.done_c = t + 1;
        end else if (op < 2'b10) begin
            r.i_lo = t + 1;        r.i_hi = t + 1 + NI;
            r.e_lo = r.i_hi + 1;   r.e_hi = r.e_lo + NE;
            r.done_c = r.e_hi + 1;
        end else begin
            r.e_lo = t + 1;        r.e_hi = t + 1 + NR;
            r.done_c = r.e_hi + 1;
        end
        return r;
    endfunction

    // Drive one command, hold valid until it is accepted, then record the prediction
    task automatic send(input logic [1:0] op, input logic col, input logic [AW-1:0] d,
                        input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                        input logic [AW-1:0] st, input logic [AW-1:0] en);
        bit got;
        got = 0;
        cmd_op = op; cmd_col = col; cmd_dest = d; cmd_src1 = s1; cmd_src2 = s2;
        cmd_start = st; cmd_endx = en;
        cmd_valid = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            if (cmd_ready === 1'b1) begin
                @(posedge clock);
                got = 1;
            end else begin
                @(negedge clock);
            end
        end
        if (!got) begin
            check("accept_timeout", 64'(cmd_ready), 64'(1));
            cmd_valid = 1'b0;
        end else begin
            @(negedge clock);
            cmd_valid = 1'b0;
            sb_q.push_back(predict(cyc, op, col, d, s1, s2, st, en));
        end
    endtask

    // Monitor: expected outputs for this cycle come from the queue head
    always @(negedge clock) begin
        exp_t r;
        int c;
        logic [63:0] e_fields;
        logic [4:0]  e_ctl;
        #2;
        if (mon_en) begin
            c = cyc;
            e_fields = idle_fields();
            e_ctl    = 5'b00001;  // {drive, done, err, busy, ready}
            if (sb_q.size() > 0) begin
                r = sb_q[0];
                e_ctl = 5'b00010;
                if (c >= r.i_lo && c <= r.i_hi) begin
                    e_fields = 64'({2'b10, r.col, r.dest, r.dest, r.dest, r.st, r.en});
                    e_ctl[4] = (c > r.i_lo);
                end else if (c >= r.e_lo && c <= r.e_hi) begin
                    e_fields = 64'({r.op, r.col, r.dest, r.s1, r.s2, r.st, r.en});
                    e_ctl[4] = (c > r.e_lo);
                end
                if (c == r.done_c) begin
                    e_ctl[3] = 1'b1;
                    e_ctl[2] = r.err;
                end
            end
            check("ctl{drive,done,err,busy,ready}", 64'({drive_en, done, err, busy, cmd_ready}),
                  64'(e_ctl));
            check("fields", 64'({mem_op, col_flag, dest_addr, src1_addr, src2_addr, start, endx}),
                  e_fields);
            if (sb_q.size() > 0 && c >= sb_q[0].done_c) void'(sb_q.pop_front());
        end
    end

    initial begin
        logic [1:0]    op;
        logic [AW-1:0] d, s1, s2, st, en;
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00; cmd_col = 1'b0;
        cmd_dest = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_start = '0; cmd_endx = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("reset_fields", 64'({mem_op, col_flag, dest_addr, src1_addr, src2_addr, start, endx}),
              idle_fields());
        check("reset_ctl", 64'({drive_en, done, err, busy, cmd_ready}), 64'(5'b00001));
        mon_en = 1'b1;
        @(negedge clock);

        // Directed: NOT, NOR, range-read, three rejects
        send(2'b00, 1'b1, 10'd5, 10'd3, 10'd0, 10'd0, 10'd1023);
        repeat (3) @(negedge clock);
        send(2'b01, 1'b0, 10'd7, 10'd1, 10'd2, 10'd0, 10'd1023);
        repeat (3) @(negedge clock);
        send(2'b11, 1'b0, 10'd0, 10'd4, 10'd9, 10'd2, 10'd40);
        repeat (3) @(negedge clock);
        send(2'b01, 1'b1, 10'd2, 10'd0, 10'd2, 10'd0, 10'd5);
        repeat (2) @(negedge clock);
        send(2'b10, 1'b0, 10'd0, 10'd9, 10'd4, 10'd0, 10'd5);
        repeat (2) @(negedge clock);
        send(2'b00, 1'b0, 10'd1, 10'd2, 10'd0, 10'd8, 10'd3);
        repeat (2) @(negedge clock);

        // Second command held valid across the whole first command
        send(2'b00, 1'b0, 10'd12, 10'd13, 10'd0, 10'd1, 10'd2);
        send(2'b10, 1'b1, 10'd0, 10'd3, 10'd3, 10'd4, 10'd4);
        repeat (8) @(negedge clock);

        // Reset during INIT_PULSE
        send(2'b00, 1'b1, 10'd20, 10'd21, 10'd0, 10'd0, 10'd100);
        repeat (2) @(negedge clock);
        #3;
        mon_en = 1'b0;
        check("pre_reset_drive", 64'(drive_en), 64'(1));
        reset_n = 1'b0;
        #1;
        check("async_reset{drive,done,start,endx}", 64'({drive_en, done, start, endx}),
              64'({1'b0, 1'b0, {AW{1'b1}}, {AW{1'b0}}}));
        sb_q.delete();
        repeat (2) begin
            @(negedge clock);
            check("no_done_in_reset", 64'(done), 64'(0));
        end
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("post_reset_ready", 64'({cmd_ready, busy}), 64'(2'b10));
        mon_en = 1'b1;
        repeat (16) @(negedge clock);

        // Randomised commands with small address pools to provoke collisions and rejects
        for (int n = 0; n < 80; n++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                d  = AW'($urandom_range(0, 7));
                s1 = AW'($urandom_range(0, 7));
                s2 = AW'($urandom_range(0, 7));
            end else begin
                d  = AW'($urandom_range(0, 1023));
                s1 = AW'($urandom_range(0, 1023));
                s2 = AW'($urandom_range(0, 1023));
            end
            st = AW'($urandom_range(0, 1023));
            en = AW'($urandom_range(0, 1023));
            if ($urandom_range(0, 5) != 0 && st > en) begin
                s1 = s1;
                {st, en} = {en, st};
            end
            repeat ($urandom_range(0, 2)) @(negedge clock);
            send(op, 1'($urandom_range(0, 1)), d, s1, s2, st, en);
        end

        for (int k = 0; k < 60 && sb_q.size() > 0; k++) @(negedge clock);
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
